// File: rtl/csa_stream_accumulator.sv
// Serial multi-operand adder: one 3:2 compressor row folds a stream of NOPS operands
// into a carry-save pair, then a single carry-propagate add resolves the total.
// Build option: define CSA_ACC_OVERFLOW_EN to keep GUARD extra bits and report cout.
module csa_stream_accumulator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NOPS  = 9,
  parameter int unsigned GUARD = $clog2(NOPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

`ifdef CSA_ACC_OVERFLOW_EN
  localparam int unsigned GW = GUARD;
`else
  // Wrapping build: guard bits are dropped and the pair is exactly WIDTH bits.
  localparam int unsigned GW = 0 * GUARD;
`endif
  localparam int unsigned IW = WIDTH + GW;
  localparam int unsigned CW = $clog2(NOPS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NOPS - 1);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] s_vec;
  logic [IW-1:0] c_vec;
  logic [CW-1:0] cnt;
  logic [IW-1:0] x_c;
  logic [IW-1:0] s_nxt_c;
  logic [IW-1:0] c_nxt_c;
  logic [IW-1:0] total_c;
  logic          in_fire_c;
  logic          out_fire_c;

  // Handshakes qualified by state only, so no in_valid/out_ready -> ready/valid path.
  always_comb begin
    in_fire_c  = 1'b0;
    out_fire_c = 1'b0;
    in_fire_c  = in_valid  && (state == ACCUM);
    out_fire_c = out_ready && (state == DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: begin
        if (in_fire_c && (cnt == LAST_IDX)) begin
          state_nxt = RESOLVE;
        end
      end
      RESOLVE: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (out_fire_c) begin
          state_nxt = ACCUM;
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // One 3:2 compressor row plus the final carry-propagate adder
  always_comb begin
    x_c     = IW'(in_data);
    s_nxt_c = s_vec ^ c_vec ^ x_c;
    c_nxt_c = ((s_vec & c_vec) | (s_vec & x_c) | (c_vec & x_c)) << 1;
    total_c = s_vec + c_vec;
  end

  // Redundant accumulator and operand counter
  always_ff @(posedge clk) begin
    if (rst) begin
      s_vec <= '0;
      c_vec <= '0;
      cnt   <= '0;
    end else if (in_fire_c) begin
      s_vec <= s_nxt_c;
      c_vec <= c_nxt_c;
      cnt   <= cnt + CW'(1);
    end else if (out_fire_c) begin
      s_vec <= '0;
      c_vec <= '0;
      cnt   <= '0;
    end
  end

  // Result register: loaded only in RESOLVE, so it survives until the next result
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (state == RESOLVE) begin
      sum <= total_c[WIDTH-1:0];
    end
  end

`ifdef CSA_ACC_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cout <= 1'b0;
    end else if (state == RESOLVE) begin
      cout <= |total_c[IW-1:WIDTH];
    end
  end
`else
  assign cout = 1'b0;
`endif

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Self-checking bench for csa_stream_accumulator: directed scenarios plus random
// streams compared against an integer-sum reference model.
module tb_csa_stream_accumulator;

  localparam int unsigned W = 16;
  localparam int unsigned N = 9;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int pass_cnt = 0;
  int total_cnt = 0;
  int hs_count = 0;
  int cyc = 0;
  int hs_edges[$];

  csa_stream_accumulator #(.WIDTH(W), .NOPS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter and handshake monitor
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && in_valid && in_ready) begin
      hs_count = hs_count + 1;
      hs_edges.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer sum of the operands
  function automatic void model(input int unsigned v[$], output logic [W-1:0] es, output logic ec);
    longint unsigned t = 0;
    foreach (v[i]) t += longint'(v[i]);
    es = W'(t);
`ifdef CSA_ACC_OVERFLOW_EN
    ec = (t >= 64'd65536);
`else
    ec = 1'b0;
`endif
  endfunction

  // Present operands in order; mode 0 = continuous, 1 = every other cycle, 2 = random gaps
  task automatic feed(input int unsigned v[$], input int mode, output bit ok);
    int i = 0;
    int t = 0;
    bit gap;
    while (i < v.size() && t < 400) begin
      gap = (mode == 1) ? (t % 2 == 1) : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (gap) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = W'(v[i]);
      end
      if (in_valid && in_ready) i++;
      step();
      t++;
    end
    in_valid = 1'b0;
    ok = (i == v.size());
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0)
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b expected 1 0 0000 0",
               in_ready, out_valid, sum, cout);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int unsigned ops[$];
    logic [W-1:0] es;
    logic ec;
    bit ok;
    ops = '{2, 3, 5, 9, 13, 18, 21, 32, 15};
    model(ops, es, ec);
    out_ready = 1'b1;
    feed(ops, 0, ok);
    total_cnt++;
    if (!ok) $display("FAIL basic_feed: operands not all accepted");
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL basic_resolve: in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL basic_latency: out_valid=%b expected 1", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (sum !== es || cout !== ec)
      $display("FAIL basic_sum: sum=%0d cout=%b expected %0d %b", sum, cout, es, ec);
    else pass_cnt++;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== es)
      $display("FAIL basic_return: in_ready=%b out_valid=%b sum=%0d expected 1 0 %0d",
               in_ready, out_valid, sum, es);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int unsigned ops[$];
    logic [W-1:0] es;
    logic ec;
    bit ok;
    repeat (N) ops.push_back(32'hFFFF);
    model(ops, es, ec);
    out_ready = 1'b1;
    feed(ops, 0, ok);
    wait_out(ok);
    total_cnt++;
    if (!ok) $display("FAIL ovf_timeout: out_valid never rose");
    else pass_cnt++;
    total_cnt++;
    if (sum !== es || cout !== ec)
      $display("FAIL ovf_sum: sum=%h cout=%b expected %h %b", sum, cout, es, ec);
    else pass_cnt++;
    step();
  endtask

  task automatic test_gaps();
    int unsigned ops[$];
    logic [W-1:0] es;
    logic ec;
    bit ok;
    ops = '{2, 3, 5, 9, 13, 18, 21, 32, 15};
    model(ops, es, ec);
    out_ready = 1'b1;
    hs_count = 0;
    feed(ops, 1, ok);
    wait_out(ok);
    total_cnt++;
    if (!ok || sum !== es)
      $display("FAIL gaps_sum: sum=%0d valid=%b expected %0d", sum, out_valid, es);
    else pass_cnt++;
    total_cnt++;
    if (hs_count !== N) $display("FAIL gaps_beats: handshakes=%0d expected %0d", hs_count, N);
    else pass_cnt++;
    step();
  endtask

  task automatic test_hold();
    int unsigned ops[$];
    int unsigned ones[$];
    logic [W-1:0] es;
    logic ec;
    bit ok;
    int bad = 0;
    int hs0;
    ops = '{2, 3, 5, 9, 13, 18, 21, 32, 15};
    model(ops, es, ec);
    out_ready = 1'b0;
    feed(ops, 0, ok);
    wait_out(ok);
    hs0 = hs_count;
    in_valid = 1'b1;
    repeat (10) begin
      in_data = W'($urandom);
      step();
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== es || cout !== ec) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL hold_stable: %0d unstable cycles expected 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (hs_count != hs0) $display("FAIL hold_accept: handshakes=%0d expected %0d", hs_count, hs0);
    else pass_cnt++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL hold_release: in_ready=%b expected 1", in_ready);
    else pass_cnt++;
    repeat (N) ones.push_back(1);
    feed(ones, 0, ok);
    wait_out(ok);
    total_cnt++;
    if (!ok || sum !== W'(N))
      $display("FAIL hold_next: sum=%0d valid=%b expected %0d", sum, out_valid, N);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    int unsigned part[$];
    int unsigned sev[$];
    bit ok;
    repeat (4) part.push_back($urandom_range(1, 65535));
    out_ready = 1'b1;
    feed(part, 0, ok);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0)
      $display("FAIL rstmid_state: in_ready=%b out_valid=%b sum=%h cout=%b expected 1 0 0000 0",
               in_ready, out_valid, sum, cout);
    else pass_cnt++;
    repeat (N) sev.push_back(7);
    feed(sev, 0, ok);
    wait_out(ok);
    total_cnt++;
    if (!ok || sum !== W'(63))
      $display("FAIL rstmid_fresh: sum=%0d valid=%b expected 63", sum, out_valid);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_done();
    int unsigned ops[$];
    logic [W-1:0] es;
    logic ec;
    bit ok;
    repeat (N) ops.push_back($urandom_range(1, 1000));
    model(ops, es, ec);
    out_ready = 1'b0;
    feed(ops, 0, ok);
    wait_out(ok);
    total_cnt++;
    if (!ok || sum !== es) $display("FAIL rstdone_pre: sum=%0d expected %0d", sum, es);
    else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1)
      $display("FAIL rstdone_post: out_valid=%b sum=%h in_ready=%b expected 0 0000 1",
               out_valid, sum, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int unsigned ops[$];
    int unsigned second[$];
    logic [W-1:0] es;
    logic ec;
    bit ok;
    for (int i = 0; i < 2 * int'(N); i++) ops.push_back($urandom_range(0, 65535));
    for (int i = int'(N); i < 2 * int'(N); i++) second.push_back(ops[i]);
    model(second, es, ec);
    out_ready = 1'b1;
    hs_edges.delete();
    feed(ops, 0, ok);
    wait_out(ok);
    total_cnt++;
    if (!ok || sum !== es || cout !== ec)
      $display("FAIL b2b_sum: sum=%h cout=%b expected %h %b", sum, cout, es, ec);
    else pass_cnt++;
    total_cnt++;
    if (hs_edges.size() != 2 * N || (hs_edges[N] - hs_edges[0]) != int'(N) + 2)
      $display("FAIL b2b_period: beats=%0d period=%0d expected %0d %0d", hs_edges.size(),
               (hs_edges.size() > N) ? hs_edges[N] - hs_edges[0] : -1, 2 * N, N + 2);
    else pass_cnt++;
    step();
  endtask

  task automatic test_random();
    int unsigned ops[$];
    logic [W-1:0] es;
    logic ec;
    bit ok;
    int dly;
    int bad;
    for (int s = 0; s < 8; s++) begin
      ops.delete();
      for (int i = 0; i < int'(N); i++)
        ops.push_back((s % 3 == 0) ? 32'hFFFF - $urandom_range(0, 15) : $urandom_range(0, 65535));
      model(ops, es, ec);
      out_ready = 1'b0;
      hs_count = 0;
      feed(ops, 2, ok);
      wait_out(ok);
      dly = $urandom_range(0, 3);
      bad = 0;
      repeat (dly) begin
        step();
        if (out_valid !== 1'b1 || sum !== es) bad++;
      end
      total_cnt++;
      if (!ok || bad != 0 || sum !== es || cout !== ec)
        $display("FAIL rand_sum[%0d]: sum=%h cout=%b unstable=%0d expected %h %b 0",
                 s, sum, cout, bad, es, ec);
      else pass_cnt++;
      total_cnt++;
      if (hs_count != N) $display("FAIL rand_beats[%0d]: handshakes=%0d expected %0d", s, hs_count, N);
      else pass_cnt++;
      out_ready = 1'b1;
      step();
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL rand_return[%0d]: in_ready=%b out_valid=%b expected 1 0", s, in_ready, out_valid);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_gaps();
    test_hold();
    test_reset_mid();
    test_reset_done();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
